// File: rtl/cpu5_pkg.sv
// Shared cpu5 definitions: memory arbiter state encoding, owner codes and defaults.
package cpu5_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE    = 2'd0;
   localparam arb_state_t ST_BUSY_IF = 2'd1;
   localparam arb_state_t ST_BUSY_LS = 2'd2;

   typedef logic arb_owner_t;

   localparam arb_owner_t OWNER_IF = 1'b0;
   localparam arb_owner_t OWNER_LS = 1'b1;

   localparam int STARVE_LIMIT_DEFAULT = 4;
   localparam int STARVE_CNT_W         = 4;

endpackage

// File: rtl/cpu5_arb_starve_cnt.sv
// Counts consecutive LS grants taken while IF waits; raises force_if at the limit.
// Only instantiated when CPU5_MEM_ARB_STARVE_EN is defined.
module cpu5_arb_starve_cnt
   import cpu5_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic if_gnt,
   input  logic ls_gnt,
   output logic force_if
);

   logic [STARVE_CNT_W-1:0] cnt;

   // An LS grant with no IF waiting breaks the starvation run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (if_gnt) begin
         cnt <= '0;
      end else if (ls_gnt) begin
         cnt <= if_req ? cnt + STARVE_CNT_W'(1) : '0;
      end
   end

   assign force_if = (cnt == STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/cpu5_mem_arbiter.sv
// Two-requester (IF, LS) arbiter for the cpu5 unified memory port, one outstanding op.
// Define CPU5_MEM_ARB_STARVE_EN to bound IF starvation under continuous LS traffic.
module cpu5_mem_arbiter
   import cpu5_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,

   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [XLEN-1:0] ls_addr,
   input  logic [XLEN-1:0] ls_wdata,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [XLEN-1:0] ls_rdata,

   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   arb_state_t state, state_nxt;
   arb_owner_t owner;
   logic       force_if;

`ifdef CPU5_MEM_ARB_STARVE_EN
   cpu5_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_gnt   (if_gnt),
      .ls_gnt   (ls_gnt),
      .force_if (force_if)
   );
`else
   logic [STARVE_CNT_W-1:0] unused_starve_limit;
   assign unused_starve_limit = STARVE_CNT_W'(STARVE_LIMIT);
   assign force_if            = 1'b0;
`endif

   assign owner = (ls_req && !(if_req && force_if)) ? OWNER_LS : OWNER_IF;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grants are gated with reset so every output reads 0 while reset is held.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      case (state)
         ST_IDLE: begin
            if (reset && (if_req || ls_req)) begin
               mem_req = 1'b1;
               if (owner == OWNER_LS) begin
                  ls_gnt    = 1'b1;
                  mem_we    = ls_we;
                  mem_addr  = ls_addr;
                  mem_wdata = ls_wdata;
                  state_nxt = ST_BUSY_LS;
               end else begin
                  if_gnt    = 1'b1;
                  mem_addr  = if_addr;
                  state_nxt = ST_BUSY_IF;
               end
            end
         end
         ST_BUSY_IF: begin
            if (mem_rvalid) begin
               if_rvalid = 1'b1;
               if_rdata  = mem_rdata;
               state_nxt = ST_IDLE;
            end
         end
         ST_BUSY_LS: begin
            if (mem_rvalid) begin
               ls_rvalid = 1'b1;
               ls_rdata  = mem_rdata;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu5_mem_arbiter.sv
// Directed, table-driven bench for cpu5_mem_arbiter plus reset and starvation sequences.
module tb_cpu5_mem_arbiter;

   localparam int XLEN = 32;

   logic            clk, reset;
   logic            if_req, ls_req, ls_we, mem_rvalid;
   logic [XLEN-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic            if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
   logic [XLEN-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

   int n_chk  = 0;
   int n_fail = 0;

   cpu5_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic            if_req;
      logic [XLEN-1:0] if_addr;
      logic            ls_req, ls_we;
      logic [XLEN-1:0] ls_addr, ls_wdata;
      logic            mem_rvalid;
      logic [XLEN-1:0] mem_rdata;
      logic            e_if_gnt, e_ls_gnt, e_mem_req, e_mem_we;
      logic [XLEN-1:0] e_mem_addr, e_mem_wdata;
      logic            e_if_rvalid;
      logic [XLEN-1:0] e_if_rdata;
      logic            e_ls_rvalid;
      logic [XLEN-1:0] e_ls_rdata;
   } vec_t;

   function automatic vec_t mk(
      input string nm,
      input logic ir, input logic [XLEN-1:0] ia,
      input logic lr, input logic lw, input logic [XLEN-1:0] la, input logic [XLEN-1:0] ld,
      input logic mv, input logic [XLEN-1:0] md,
      input logic eig, input logic elg, input logic emr, input logic emw,
      input logic [XLEN-1:0] ema, input logic [XLEN-1:0] emd,
      input logic eiv, input logic [XLEN-1:0] eid,
      input logic elv, input logic [XLEN-1:0] eld);
      vec_t v;
      v.name = nm;
      v.if_req = ir; v.if_addr = ia;
      v.ls_req = lr; v.ls_we = lw; v.ls_addr = la; v.ls_wdata = ld;
      v.mem_rvalid = mv; v.mem_rdata = md;
      v.e_if_gnt = eig; v.e_ls_gnt = elg; v.e_mem_req = emr; v.e_mem_we = emw;
      v.e_mem_addr = ema; v.e_mem_wdata = emd;
      v.e_if_rvalid = eiv; v.e_if_rdata = eid;
      v.e_ls_rvalid = elv; v.e_ls_rdata = eld;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_outs(input vec_t v);
      chk({v.name, ".if_gnt"},    XLEN'(if_gnt),    XLEN'(v.e_if_gnt));
      chk({v.name, ".ls_gnt"},    XLEN'(ls_gnt),    XLEN'(v.e_ls_gnt));
      chk({v.name, ".mem_req"},   XLEN'(mem_req),   XLEN'(v.e_mem_req));
      chk({v.name, ".mem_we"},    XLEN'(mem_we),    XLEN'(v.e_mem_we));
      chk({v.name, ".mem_addr"},  mem_addr,         v.e_mem_addr);
      chk({v.name, ".mem_wdata"}, mem_wdata,        v.e_mem_wdata);
      chk({v.name, ".if_rvalid"}, XLEN'(if_rvalid), XLEN'(v.e_if_rvalid));
      chk({v.name, ".if_rdata"},  if_rdata,         v.e_if_rdata);
      chk({v.name, ".ls_rvalid"}, XLEN'(ls_rvalid), XLEN'(v.e_ls_rvalid));
      chk({v.name, ".ls_rdata"},  ls_rdata,         v.e_ls_rdata);
   endtask

   // Drive on the falling edge, compare the combinational outputs 1 ns later.
   task automatic apply(input vec_t v);
      @(negedge clk);
      if_req = v.if_req; if_addr = v.if_addr;
      ls_req = v.ls_req; ls_we = v.ls_we; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata;
      mem_rvalid = v.mem_rvalid; mem_rdata = v.mem_rdata;
      #1;
      check_outs(v);
   endtask

   vec_t tbl[$];
   vec_t z;

   initial begin
      reset = 1'b0;
      if_req = 0; ls_req = 0; ls_we = 0; mem_rvalid = 0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;

      //          name           ir ia        lr lw la        ld            mv md            ig lg mr mw ma        md            iv id            lv ld
      tbl.push_back(mk("rst_req",   1, 32'h100, 1, 1, 32'h40, 32'hDEADBEEF, 1, 32'h1111,     0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("rst_idle",  0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("if_gnt",    1, 32'h100, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h100,  32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("if_wait",   0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("if_rsp",    0, 32'h0,   0, 0, 32'h0,  32'h0,        1, 32'hCAFE0001, 0, 0, 0, 0, 32'h0,    32'h0,        1, 32'hCAFE0001, 0, 32'h0));
      tbl.push_back(mk("idle_rv",   0, 32'h0,   0, 0, 32'h0,  32'h0,        1, 32'h12345678, 0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("both_ls",   1, 32'h200, 1, 1, 32'h40, 32'hDEADBEEF, 0, 32'h0,        0, 1, 1, 1, 32'h40,   32'hDEADBEEF, 0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("st_wait",   1, 32'h200, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("st_rsp",    1, 32'h200, 0, 0, 32'h0,  32'h0,        1, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h0));
      tbl.push_back(mk("if_after",  1, 32'h200, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 0, 1, 0, 32'h200,  32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("ls_blk",    0, 32'h0,   1, 0, 32'h80, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("if_rsp_ls", 0, 32'h0,   1, 0, 32'h80, 32'h0,        1, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h0,    32'h0,        1, 32'hA5A5A5A5, 0, 32'h0));
      tbl.push_back(mk("ls_ld_gnt", 0, 32'h0,   1, 0, 32'h80, 32'h0,        0, 32'h0,        0, 1, 1, 0, 32'h80,   32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("if_drop_a", 1, 32'h300, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));
      tbl.push_back(mk("ld_rsp",    0, 32'h0,   0, 0, 32'h0,  32'h0,        1, 32'h0BADF00D, 0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        1, 32'h0BADF00D));
      tbl.push_back(mk("if_drop_b", 0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         if (i == 1) reset = 1'b1;
      end

      // Reset while a load is outstanding; a late completion must be dropped.
      z = mk("x", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(mk("mid_gnt", 0, 0, 1, 0, 32'h600, 0, 0, 0, 0, 1, 1, 0, 32'h600, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0; ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h700;
      #1;
      z.name = "mid_rst";
      check_outs(z);
      @(posedge clk);
      #1;
      if_req = 1'b0;
      reset = 1'b1;
      apply(mk("late_rv", 0, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(mk("post_gnt", 1, 32'h700, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h700, 0, 0, 0, 0, 0));
      apply(mk("post_rsp", 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0));

      // Both requesting back-to-back: with the guard, every fifth grant goes to IF.
      for (int k = 0; k < 10; k++) begin
         logic exp_if;
`ifdef CPU5_MEM_ARB_STARVE_EN
         exp_if = (k % 5 == 4);
`else
         exp_if = 1'b0;
`endif
         apply(mk($sformatf("stv_gnt%0d", k), 1, 32'h800, 1, 0, 32'h900, 0, 0, 0,
                  exp_if, !exp_if, 1, 0, exp_if ? 32'h800 : 32'h900, 0, 0, 0, 0, 0));
         apply(mk($sformatf("stv_rsp%0d", k), 1, 32'h800, 1, 0, 32'h900, 0, 1, 32'(k + 1),
                  0, 0, 0, 0, 0, 0, exp_if, exp_if ? 32'(k + 1) : 32'h0,
                  !exp_if, exp_if ? 32'h0 : 32'(k + 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
